comp_serial_ctrl: RTL
=====================

Name: comp_serial_ctrl

Overview:
Sequencing controller for the 2-bit magnitude comparator slice. Compares two WIDTH-bit operands 2 bits per cycle, MSB pair first, by driving an external 2-bit comparator and consuming its higher/lower/same outputs. Provides a start/busy/done handshake and registered, held results for the surrounding control logic.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise)
NSLICE, WIDTH/2, derived (localparam), number of 2-bit slices; counter width = clog2(NSLICE), minimum 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a compare; sampled only in IDLE or DONE
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
slice_a  output  2  current pair of A to the comparator; [1] is the more significant bit
slice_b  output  2  current pair of B to the comparator; [1] is the more significant bit
slice_higher  input  1  comparator result A>B for the current pair
slice_lower  input  1  comparator result A<B for the current pair
slice_same  input  1  comparator result A==B for the current pair
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse when the result is valid
ahigher  output  1  final A>B, held
alower  output  1  final A<B, held
asame  output  1  final A==B, held
slice_err  output  1  sticky: the comparator returned a result that was not one-hot during this compare

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. busy, done, ahigher, alower, asame, slice_err = 0. Shift registers and counter = 0, so slice_a = slice_b = 0. Reset overrides everything, including mid-SCAN.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1:
  - Load shift regs with a and b; cnt = NSLICE-1.
  - Clear ahigher, alower, asame, slice_err.
  - Go to SCAN; busy=1 from the next cycle.
- SCAN:
  - slice_a/slice_b = top 2 bits of the shift regs (registered source, combinational tap).
  - The comparator is combinational; its result is sampled at the end of the same cycle.
  - Decode priority: higher > lower > same.
  - slice_err is set if the result is not exactly one-hot. All-zero decodes as same.
  - Decode higher or lower: latch the matching result flag, go to DONE.
  - Decode same with cnt==0: set asame, go to DONE.
  - Decode same with cnt!=0: shift both regs left by 2, cnt -= 1.
- DONE (one cycle): done=1, busy=0.
  - start=1: accept exactly as from IDLE (back-to-back), next state SCAN.
  - Otherwise go to IDLE.
- start in SCAN is ignored; it is neither queued nor does it abort.
- Result flags are one-hot after done and hold until the next accepted start.
- Latency: start accepted at edge k, pair i (0 = MSB pair) is evaluated in cycle k+1+i, done is high in cycle k+2+i. Worst case and equal operands: done at k+NSLICE+1.
- WIDTH=2: a single SCAN cycle; done at k+2.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined: the controller leaves SCAN at the first unequal pair, as described above; latency depends on the data.
- Undefined: constant-time operation.
  - SCAN always runs NSLICE cycles.
  - The first unequal pair's decision is latched into an internal decided flag; later pairs are still driven but ignored for the result.
  - asame is set only if all pairs were same.
  - slice_err still accumulates over all pairs.
  - done is always at k+NSLICE+1.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start pulse at edge k -> done=1 in cycle k+5; asame=1, ahigher=alower=0, slice_err=0; busy high in cycles k+1..k+4.
- a=0xC0, b=0x80 -> first pair is 11 vs 10, ahigher=1. With EARLY_TERM_EN, done at k+2. Without it, done at k+5, slice_a sequence 3,0,0,0.
- a=0x12, b=0x13 -> alower=1 decided on the last pair; done at k+5 in both builds; slice_b sequence 0,1,0,3.
- Hold start=1 throughout SCAN with new a/b values -> result is for the first operands only. Then rst_n=0 for one edge mid-SCAN -> next cycle busy=done=asame=ahigher=alower=0 and state IDLE.
- Comparator model forces slice_higher=slice_lower=1 on the first pair -> ahigher=1, slice_err=1. The next start clears slice_err to 0.
- start=1 in the DONE cycle with a=0x01, b=0x02 -> no IDLE cycle; busy=1 the next cycle; done 5 cycles later with alower=1. The previous result holds until that accept edge.

Source files
------------

// File: rtl/comp_serial_ctrl.sv
// Sequencing controller for the 2-bit magnitude comparator slice: walks two WIDTH-bit operands
// MSB pair first. Define EARLY_TERM_EN to stop at the first unequal pair; otherwise constant-time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start, last result held
//   S_SCAN | driving one operand pair per cycle to the external comparator
//   S_DONE | one-cycle done pulse; start here is accepted back-to-back
module comp_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             slice_higher,
    input  logic             slice_lower,
    input  logic             slice_same,
    output logic             busy,
    output logic             done,
    output logic             ahigher,
    output logic             alower,
    output logic             asame,
    output logic             slice_err
);

    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("comp_serial_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_a_nxt, sh_b, sh_b_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ahigher_nxt, alower_nxt, asame_nxt, slice_err_nxt;
    logic             dec_higher, dec_lower, dec_same, one_hot;
`ifndef EARLY_TERM_EN
    logic             decided, decided_nxt;
`endif

    assign slice_a = sh_a[WIDTH-1 -: 2];
    assign slice_b = sh_b[WIDTH-1 -: 2];
    assign busy    = (state == S_SCAN);
    assign done    = (state == S_DONE);

    // Priority higher > lower > same; an all-zero result falls through to same.
    assign dec_higher = slice_higher;
    assign dec_lower  = ~slice_higher & slice_lower;
    assign dec_same   = ~slice_higher & ~slice_lower;
    assign one_hot    = (slice_higher ^ slice_lower ^ slice_same) &
                        ~(slice_higher & slice_lower & slice_same);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            ahigher   <= 1'b0;
            alower    <= 1'b0;
            asame     <= 1'b0;
            slice_err <= 1'b0;
`ifndef EARLY_TERM_EN
            decided   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sh_a      <= sh_a_nxt;
            sh_b      <= sh_b_nxt;
            cnt       <= cnt_nxt;
            ahigher   <= ahigher_nxt;
            alower    <= alower_nxt;
            asame     <= asame_nxt;
            slice_err <= slice_err_nxt;
`ifndef EARLY_TERM_EN
            decided   <= decided_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        sh_a_nxt      = sh_a;
        sh_b_nxt      = sh_b;
        cnt_nxt       = cnt;
        ahigher_nxt   = ahigher;
        alower_nxt    = alower;
        asame_nxt     = asame;
        slice_err_nxt = slice_err;
`ifndef EARLY_TERM_EN
        decided_nxt   = decided;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sh_a_nxt      = a;
                    sh_b_nxt      = b;
                    cnt_nxt       = CW'(NSLICE - 1);
                    ahigher_nxt   = 1'b0;
                    alower_nxt    = 1'b0;
                    asame_nxt     = 1'b0;
                    slice_err_nxt = 1'b0;
`ifndef EARLY_TERM_EN
                    decided_nxt   = 1'b0;
`endif
                    state_nxt     = S_SCAN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!one_hot) slice_err_nxt = 1'b1;
`ifdef EARLY_TERM_EN
                if (dec_higher) begin
                    ahigher_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else if (dec_lower) begin
                    alower_nxt = 1'b1;
                    state_nxt  = S_DONE;
                end else if (cnt == '0) begin
                    asame_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    sh_a_nxt = sh_a << 2;
                    sh_b_nxt = sh_b << 2;
                    cnt_nxt  = cnt - 1'b1;
                end
`else
                // Only the first unequal pair decides; later pairs still run for fixed timing.
                if (!decided && dec_higher) begin
                    ahigher_nxt = 1'b1;
                    decided_nxt = 1'b1;
                end else if (!decided && dec_lower) begin
                    alower_nxt  = 1'b1;
                    decided_nxt = 1'b1;
                end
                if (cnt == '0) begin
                    if (!decided && dec_same) asame_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    sh_a_nxt = sh_a << 2;
                    sh_b_nxt = sh_b << 2;
                    cnt_nxt  = cnt - 1'b1;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
